// File: rtl/sp_dram_word_port.sv
// sp_dram_word_port: 32-bit word front end for the 128-bit sp_dram line port.
// Word writes become one masked line write with the word replicated on all
// four lanes; word reads fetch one line and return the addressed lane.
// Optional single-line read cache: define SP_DRAM_WORD_PORT_LINE_CACHE_EN.
module sp_dram_word_port #(
  parameter int ADDR_WIDTH = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [31:0]           din,
  input  logic                  we_in,
  input  logic                  re_in,
  output logic                  ready_out,
  output logic [31:0]           dout,
  output logic                  avail_out,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [127:0]          mem_din,
  output logic [15:0]           mem_mask,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [127:0]          mem_dout,
  input  logic                  mem_ready
);

  // state | meaning
  // IDLE  | ready for a request (cache hits are served from here)
  // WRITE | line write waiting for mem_ready
  // READ  | line read waiting for mem_ready
  // WAIT  | read issued, waiting for returned line data
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  logic [1:0]            r_state;
  logic [1:0]            r_lane;
  logic [ADDR_WIDTH-3:0] r_addr;
  logic [127:0]          r_din;
  logic [15:0]           r_mask;
  logic [31:0]           r_dout;
  logic                  r_avail;

  logic [31:0]           w_rd_word;
  logic [15:0]           w_mask_new;
  logic                  w_hit;
  logic [31:0]           w_hit_word;

  assign w_rd_word  = mem_dout[{r_lane, 5'b00000} +: 32];
  assign w_mask_new = 16'h000F << {addr_in[1:0], 2'b00};

`ifdef SP_DRAM_WORD_PORT_LINE_CACHE_EN
  logic [127:0]          r_line;
  logic [ADDR_WIDTH-3:0] r_tag;
  logic                  r_valid;

  assign w_hit      = r_valid && (r_tag == addr_in[ADDR_WIDTH-1:2]);
  assign w_hit_word = r_line[{addr_in[1:0], 5'b00000} +: 32];

  // Line cache: filled on read miss return, write-through on write hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_line  <= '0;
      r_tag   <= '0;
      r_valid <= 1'b0;
    end else if (r_state == S_IDLE && we_in && w_hit) begin
      r_line[{addr_in[1:0], 5'b00000} +: 32] <= din;
    end else if (r_state == S_WAIT && mem_ready) begin
      r_line  <= mem_dout;
      r_tag   <= r_addr;
      r_valid <= 1'b1;
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_hit_word = 32'h0;
`endif

  // Request sequencing, latched command fields and read-data return.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_lane  <= 2'd0;
      r_addr  <= '0;
      r_din   <= '0;
      r_mask  <= '0;
      r_dout  <= '0;
      r_avail <= 1'b0;
    end else begin
      r_avail <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (we_in) begin
            r_state <= S_WRITE;
            r_addr  <= addr_in[ADDR_WIDTH-1:2];
            r_lane  <= addr_in[1:0];
            r_din   <= {4{din}};
            r_mask  <= w_mask_new;
          end else if (re_in) begin
            r_addr <= addr_in[ADDR_WIDTH-1:2];
            r_lane <= addr_in[1:0];
            if (w_hit) begin
              r_dout  <= w_hit_word;
              r_avail <= 1'b1;
            end else begin
              r_state <= S_READ;
            end
          end
        end
        S_WRITE: if (mem_ready) r_state <= S_IDLE;
        S_READ:  if (mem_ready) r_state <= S_WAIT;
        S_WAIT: begin
          if (mem_ready) begin
            r_dout  <= w_rd_word;
            r_avail <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes follow mem_ready directly so each fires for exactly one cycle.
  always_comb begin
    ready_out = (r_state == S_IDLE) && !rst;
    mem_we    = (r_state == S_WRITE) && mem_ready;
    mem_re    = (r_state == S_READ) && mem_ready;
  end

  assign mem_addr  = r_addr;
  assign mem_din   = r_din;
  assign mem_mask  = r_mask;
  assign dout      = r_dout;
  assign avail_out = r_avail;

endmodule

// File: tb/tb_sp_dram_word_port.sv
module tb_sp_dram_word_port;

`ifdef SP_DRAM_WORD_PORT_LINE_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [27:0]  addr_in;
  logic [31:0]  din;
  logic         we_in;
  logic         re_in;
  logic         ready_out;
  logic [31:0]  dout;
  logic         avail_out;
  logic [25:0]  mem_addr;
  logic [127:0] mem_din;
  logic [15:0]  mem_mask;
  logic         mem_we;
  logic         mem_re;
  logic [127:0] mem_dout;
  logic         mem_ready;

  sp_dram_word_port #(.ADDR_WIDTH(28)) dut (
    .clk(clk), .rst(rst), .addr_in(addr_in), .din(din), .we_in(we_in),
    .re_in(re_in), .ready_out(ready_out), .dout(dout), .avail_out(avail_out),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_mask(mem_mask),
    .mem_we(mem_we), .mem_re(mem_re), .mem_dout(mem_dout),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Backing DRAM contents (environment) and word-level reference memory.
  logic [127:0] dram [logic [25:0]];
  logic [31:0]  refm [logic [27:0]];

  function automatic logic [31:0] init_word(input logic [27:0] w);
    logic [31:0] t;
    t = {4'h0, w} * 32'h9E3779B1;
    return t ^ 32'hA5A50F0F;
  endfunction

  function automatic logic [127:0] dram_read(input logic [25:0] a);
    if (dram.exists(a)) return dram[a];
    return {init_word({a, 2'd3}), init_word({a, 2'd2}), init_word({a, 2'd1}), init_word({a, 2'd0})};
  endfunction

  function automatic logic [31:0] ref_read(input logic [27:0] w);
    if (refm.exists(w)) return refm[w];
    return init_word(w);
  endfunction

  task automatic preload_line(input logic [25:0] a, input logic [127:0] v);
    dram[a] = v;
    for (int k = 0; k < 4; k++) refm[{a, k[1:0]}] = v[32*k +: 32];
  endtask

  // DRAM side: drops ready the cycle after a read strobe, else random or forced.
  logic force_en  = 1'b1;
  logic force_val = 1'b1;
  logic re_last   = 1'b0;

  always @(posedge clk) begin
    #1;
    if (re_last)       mem_ready = 1'b0;
    else if (force_en) mem_ready = force_val;
    else               mem_ready = ($urandom_range(0, 9) < 6);
    mem_dout = dram_read(mem_addr);
  end

  // Transaction-level model: busy 0=none, 1=write pending, 2=read not yet
  // issued, 3=read issued awaiting data.
  int          busy      = 0;
  bit          ret_now   = 1'b0;
  logic [25:0] cur_line  = '0;
  logic [15:0] cur_mask  = '0;
  logic [31:0] cur_din   = '0;
  logic [31:0] exp_word  = '0;
  logic [31:0] last_dout = '0;
  logic [27:0] wr_addr   = '0;
  logic [31:0] wr_old    = '0;
  bit          c_valid   = 1'b0;
  logic [25:0] c_tag     = '0;

  always @(negedge clk) begin : mon
    bit ret_next;
    logic [127:0] bm;
    if (rst) begin
      check("rst_ready_out", ready_out, 0);
      check("rst_avail_out", avail_out, 0);
      check("rst_dout", dout, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_re", mem_re, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_din", mem_din, 0);
      check("rst_mem_mask", mem_mask, 0);
      if (busy == 1) refm[wr_addr] = wr_old;
      busy = 0; ret_now = 1'b0; last_dout = '0; c_valid = 1'b0; re_last = 1'b0;
    end else begin
      check("ready_out", ready_out, busy == 0);
      check("avail_out", avail_out, ret_now);
      if (ret_now) last_dout = exp_word;
      check("dout", dout, last_dout);
      check("mem_we", mem_we, (busy == 1) && mem_ready);
      check("mem_re", mem_re, (busy == 2) && mem_ready);
      if (busy != 0) check("mem_addr", mem_addr, cur_line);
      if (mem_we) begin
        check("mem_mask", mem_mask, cur_mask);
        check("mem_din", mem_din, {4{cur_din}});
        for (int i = 0; i < 16; i++) bm[8*i +: 8] = {8{mem_mask[i]}};
        dram[mem_addr] = (dram_read(mem_addr) & ~bm) | (mem_din & bm);
      end
      re_last = mem_re;
      ret_next = 1'b0;
      case (busy)
        1: if (mem_ready) busy = 0;
        2: if (mem_ready) busy = 3;
        3: if (mem_ready) begin
             busy = 0; ret_next = 1'b1; c_valid = 1'b1; c_tag = cur_line;
           end
        default: begin
          if (we_in) begin
            busy     = 1;
            wr_addr  = addr_in;
            wr_old   = ref_read(addr_in);
            refm[addr_in] = din;
            cur_line = addr_in[27:2];
            for (int i = 0; i < 16; i++) cur_mask[i] = ((i / 4) == int'(addr_in[1:0]));
            cur_din  = din;
          end else if (re_in) begin
            cur_line = addr_in[27:2];
            exp_word = ref_read(addr_in);
            if (CACHE && c_valid && (c_tag == addr_in[27:2])) ret_next = 1'b1;
            else busy = 2;
          end
        end
      endcase
      ret_now = ret_next;
    end
  end

  task automatic do_req(input logic w, input logic r, input logic [27:0] a, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    we_in = w; re_in = r; addr_in = a; din = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready_out) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    we_in = 1'b0; re_in = 1'b0;
    check("req_accepted", ok, 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready_out) begin ok = 1'b1; break; end
    end
    check("idle_reached", ok, 1);
  endtask

  // Counts negedges after the accept edge until avail_out (1 = next cycle).
  task automatic wait_avail(output int lat);
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (avail_out) begin lat = i; break; end
    end
    check("avail_seen", lat != 0, 1);
  endtask

  initial begin
    int n_we, n_re, n_av, lat, kind;
    logic [27:0] a;
    we_in = 1'b0; re_in = 1'b0; addr_in = '0; din = '0;
    mem_ready = 1'b0; mem_dout = '0;

    repeat (3) @(negedge clk);
    check("reset_ready_low", ready_out, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("reset_release_ready", ready_out, 1);

    // write lane 2
    do_req(1'b1, 1'b0, 28'h0000006, 32'hDEADBEEF);
    @(negedge clk);
    check("w2_we", mem_we, 1);
    check("w2_addr", mem_addr, 26'h1);
    check("w2_mask", mem_mask, 16'h0F00);
    check("w2_din", mem_din, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF);
    wait_idle();

    // read lane 3 with DRAM stalling three cycles
    preload_line(26'h1, 128'h44444444_33333333_22222222_11111111);
    do_req(1'b0, 1'b1, 28'h0000007, 32'h0);
    @(negedge clk);
    check("rd_re", mem_re, 1);
    check("rd_addr", mem_addr, 26'h1);
    force_val = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rd_wait_avail", avail_out, 0);
    end
    force_val = 1'b1;
    n_av = 0;
    repeat (6) begin
      @(negedge clk);
      if (avail_out) begin
        n_av++;
        check("rd_dout", dout, 32'h44444444);
      end
    end
    check("rd_avail_count", n_av, 1);

    // back-pressure on write
    force_val = 1'b0;
    do_req(1'b1, 1'b0, 28'h0000123, 32'h13572468);
    repeat (5) begin
      @(negedge clk);
      check("bp_we_low", mem_we, 0);
      check("bp_ready_low", ready_out, 0);
    end
    force_val = 1'b1;
    n_we = 0;
    repeat (4) begin
      @(negedge clk);
      if (mem_we) n_we++;
    end
    check("bp_we_count", n_we, 1);

    // simultaneous write and read: write wins
    do_req(1'b1, 1'b1, 28'h0000045, 32'h0BADCAFE);
    n_we = 0; n_re = 0; n_av = 0;
    repeat (8) begin
      @(negedge clk);
      if (mem_we) n_we++;
      if (mem_re) n_re++;
      if (avail_out) n_av++;
    end
    check("sim_we_count", n_we, 1);
    check("sim_re_count", n_re, 0);
    check("sim_avail_count", n_av, 0);

    // read miss, write into same line, read back
    force_en = 1'b0;
    do_req(1'b0, 1'b1, 28'h0000010, 32'h0);
    wait_idle();
    do_req(1'b1, 1'b0, 28'h0000011, 32'hCAFEF00D);
    wait_idle();
    do_req(1'b0, 1'b1, 28'h0000011, 32'h0);
    wait_avail(lat);
    check("rb_dout", dout, 32'hCAFEF00D);
`ifdef SP_DRAM_WORD_PORT_LINE_CACHE_EN
    check("hit_latency", lat, 1);
`else
    check("miss_latency_min", lat >= 3, 1);
`endif

    // asynchronous reset in the middle of WAIT
    force_en = 1'b1; force_val = 1'b1;
    do_req(1'b0, 1'b1, 28'h0000020, 32'h0);
    @(negedge clk);
    check("rw_re", mem_re, 1);
    force_val = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check("rw_mem_re", mem_re, 0);
    check("rw_mem_we", mem_we, 0);
    check("rw_avail", avail_out, 0);
    check("rw_ready", ready_out, 0);
    check("rw_dout", dout, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rw_ready_after", ready_out, 1);
    check("rw_avail_after", avail_out, 0);
    force_val = 1'b1;
    do_req(1'b0, 1'b1, 28'h0000011, 32'h0);
    wait_avail(lat);
    check("post_reset_miss_latency", lat >= 3, 1);
    check("post_reset_dout", dout, 32'hCAFEF00D);

    // randomized traffic
    force_en = 1'b0;
    for (int t = 0; t < 300; t++) begin
      kind = $urandom_range(0, 9);
      if ($urandom_range(0, 7) == 0) a = 28'($urandom);
      else a = {23'h0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      do_req(kind < 4 || kind == 9, kind >= 4, a, $urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end
    wait_idle();
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sp_dram_word_port.md
# sp_dram_word_port

32-bit word-access front end for the 128-bit `sp_dram` line port.
- Accepts single-word reads and writes from kernel logic.
- Writes: generates the byte mask and replicated line data, then issues a one-line write.
- Reads: issues a one-line read and extracts the addressed 32-bit lane.
- Sits directly upstream of `sp_dram`. Its `mem_*` ports connect one-to-one to that block's `addr`/`din`/`dout`/`mask`/`we`/`re`/`ready`.

## Interface
- `ADDR_WIDTH`, 28, word address width. Bits [1:0] select the lane; bits [27:2] form the 26-bit line address.
- `clk` input 1: the single clock; `sp_dram` shares it.
- `rst` input 1: asynchronous, active-high reset.
- `addr_in` input 28: word address of the request.
- `din` input 32: write data.
- `we_in` input 1: write request; accepted when `ready_out`=1.
- `re_in` input 1: read request; accepted when `ready_out`=1.
- `ready_out` output 1: block is in IDLE and can accept a request.
- `dout` output 32: read data, valid while `avail_out`=1.
- `avail_out` output 1: one-cycle pulse marking returned read data.
- `mem_addr` output 26: line address to DRAM.
- `mem_din` output 128: line write data.
- `mem_mask` output 16: byte enable, 1 = byte written.
- `mem_we` output 1: line write strobe.
- `mem_re` output 1: line read strobe.
- `mem_dout` input 128: line read data.
- `mem_ready` input 1: DRAM can accept a command, or read data is ready.

## Operation
- States: IDLE, WRITE, READ, WAIT.
- **IDLE**
  - `ready_out` = 1.
  - `we_in`=1: latch address and data, go to WRITE.
  - Else `re_in`=1: latch address, go to READ (cache hit: see Configuration).
  - `we_in` and `re_in` both high: write wins and the read is dropped.
- **WRITE**
  - `mem_we` = `mem_ready`, combinational.
  - When `mem_ready`=1: `mem_we` pulses for exactly 1 cycle, then go to IDLE.
  - While `mem_ready`=0: hold in WRITE.
- **READ**
  - `mem_re` = `mem_ready`, combinational.
  - When `mem_ready`=1: pulse `mem_re` for 1 cycle, go to WAIT.
- **WAIT**
  - DRAM drops `mem_ready` in the cycle after `mem_re`.
  - Exit on the first cycle with `mem_ready`=1: capture lane `addr[1:0]` of `mem_dout` into `dout`, pulse `avail_out`, go to IDLE.
- **Lane mapping**
  - Lane k = `mem_dout`[32k+31:32k].
  - `mem_mask` has bits [4k+3:4k] set and all other bits clear.
  - `mem_din` = `din` replicated four times.
- `mem_addr` = latched `addr[27:2]`; held stable from accept until return to IDLE.
- Requests presented while `ready_out`=0 are ignored. The client must hold them until accepted.
- **Reset** (asynchronous, including mid-transaction): state goes to IDLE, and the following all read 0:
  - `ready_out` (while `rst` is high), `avail_out`, `dout`, `mem_we`, `mem_re`, `mem_addr`, `mem_din`, `mem_mask`.
  - Any in-flight request is abandoned.

## Timing
- **Write**, accepted at edge N:
  - `mem_we` is high in the first cycle ≥ N+1 with `mem_ready`=1.
  - `ready_out` returns the cycle after that.
  - Minimum occupancy: 2 cycles.
- **Read miss**, accepted at edge N:
  - `mem_re` in cycle N+1 at the earliest.
  - WAIT lasts ≥1 cycle.
  - `avail_out`/`dout` are registered: valid the cycle after the WAIT exit edge.
  - Minimum latency: accept to `avail_out` = 3 cycles.
- `avail_out` and `ready_out` rise in the same cycle, so a new request may be accepted while `avail_out`=1.
- `dout` holds its value until the next read returns.

## Configuration
- Macro: `SP_DRAM_WORD_PORT_LINE_CACHE_EN`.
- **Defined:** keep a single line register with a 26-bit tag and a valid bit.
  - Read miss fill sets the line and valid.
  - Read hit (valid and tag == `addr[27:2]`): no DRAM access, state stays IDLE, `avail_out` the next cycle (latency 1), `ready_out` stays high.
  - Write hit: update the cached lane and also write to DRAM (write-through).
  - Write miss: cache unchanged.
  - Reset clears valid.
- **Undefined:** no line register; every read goes through READ/WAIT.

## Test plan
- **Reset:** assert `rst` mid-WAIT → `mem_re`/`mem_we`/`avail_out` all 0 immediately; after release, `ready_out`=1 and state is IDLE.
- **Write lane 2:** write `addr`=0x0000006, `din`=0xDEADBEEF → one `mem_we` pulse with `mem_addr`=0x1, `mem_mask`=0x0F00, `mem_din`=4×0xDEADBEEF.
- **Read with delay:**
  - Stimulus: read `addr`=0x0000007; `mem_ready` held low 3 cycles in WAIT; `mem_dout`=0x44444444_33333333_22222222_11111111.
  - Response: single `avail_out` pulse with `dout`=0x44444444.
- **Back-pressure:** `mem_ready`=0 for 5 cycles in WRITE → `mem_we` stays low and `ready_out`=0 throughout; exactly one `mem_we` when `mem_ready` rises.
- **Simultaneous requests:** `we_in`=`re_in`=1 in the same cycle → only the write is issued; `avail_out` never pulses.
- **With `SP_DRAM_WORD_PORT_LINE_CACHE_EN`:**
  - Stimulus: read 0x10 (miss), write 0x11=0xCAFEF00D, then read 0x11.
  - Response: the second read has no `mem_re`, gives `avail_out` 1 cycle after accept, and `dout`=0xCAFEF00D.
